// File: rtl/sbox_share_ctrl_pkg.sv
// ============================================================================
// Module  : sbox_share_ctrl_pkg
// Brief   : Shared widths, limits and direction encoding for the S-box sharing
//           controller and the datapath wrappers around it.
// Revision: 1.0
// ============================================================================
`default_nettype none

package sbox_share_ctrl_pkg;

    localparam int SBOX_W  = 8;
    localparam int MAX_REQ = 8;
    localparam int MAX_LAT = 8;

    typedef enum logic {
        DIR_FWD = 1'b0,
        DIR_INV = 1'b1
    } sbox_dir_e;

    typedef logic [SBOX_W-1:0] sbox_byte_t;

endpackage

`default_nettype wire

// File: rtl/sbox_share_ctrl_if.sv
// ============================================================================
// Module  : sbox_share_ctrl_if
// Brief   : Requester, S-box datapath and response bundle of the controller.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface sbox_share_ctrl_if #(
    parameter int N_REQ = 4
);
    import sbox_share_ctrl_pkg::*;

    logic [N_REQ-1:0]        req_valid;
    logic [SBOX_W*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]        req_inv;
    logic [N_REQ-1:0]        req_ready;
    logic                    flush;
    sbox_byte_t              sbox_x;
    logic                    sbox_inv;
    logic                    sbox_vld;
    sbox_byte_t              sbox_y;
    logic [N_REQ-1:0]        rsp_valid;
    sbox_byte_t              rsp_data;
    logic                    busy;

    // Controller side
    modport slave (
        input  req_valid, req_data, req_inv, flush, sbox_y,
        output req_ready, sbox_x, sbox_inv, sbox_vld, rsp_valid, rsp_data, busy
    );

    // Requesters plus the external S-box datapath
    modport master (
        output req_valid, req_data, req_inv, flush, sbox_y,
        input  req_ready, sbox_x, sbox_inv, sbox_vld, rsp_valid, rsp_data, busy
    );

endinterface

`default_nettype wire

// File: rtl/sbox_rr_arbiter.sv
// ============================================================================
// Module  : sbox_rr_arbiter
// Brief   : Combinational round-robin pick: first request at or above the
//           pointer, wrapping, returned as one-hot grant and binary index.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sbox_rr_arbiter #(
    parameter int N_REQ = 4
) (
    input  wire logic [N_REQ-1:0]         req_i,
    input  wire logic [$clog2(N_REQ)-1:0] ptr_i,
    input  wire logic                     en_i,
    output logic      [N_REQ-1:0]         gnt_o,
    output logic      [$clog2(N_REQ)-1:0] idx_o,
    output logic                          any_o
);

    localparam int ID_W = $clog2(N_REQ);

    logic [ID_W:0] w_cand;
    logic          w_found;

    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        w_found = 1'b0;
        w_cand  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            // Candidate index (ptr + k) mod N_REQ; sum never reaches 2*N_REQ
            w_cand = {1'b0, ptr_i} + (ID_W+1)'(k);
            if (w_cand >= (ID_W+1)'(N_REQ)) begin
                w_cand = w_cand - (ID_W+1)'(N_REQ);
            end
            if (en_i && !w_found && req_i[w_cand[ID_W-1:0]]) begin
                gnt_o[w_cand[ID_W-1:0]] = 1'b1;
                idx_o                   = w_cand[ID_W-1:0];
                w_found                 = 1'b1;
            end
        end
    end

    assign any_o = w_found;

endmodule

`default_nettype wire

// File: rtl/sbox_share_ctrl.sv
// ============================================================================
// Module  : sbox_share_ctrl
// Brief   : Round-robin sharing of one pipelined merged S-box among N_REQ
//           requesters, with a tag pipe steering results back to the issuer.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sbox_share_ctrl
    import sbox_share_ctrl_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int SBOX_LAT = 3
) (
    input  wire logic        clk,
    input  wire logic        rst,
    sbox_share_ctrl_if.slave bus
);

    localparam int ID_W = $clog2(N_REQ);

    logic [N_REQ-1:0] w_gnt;
    logic [ID_W-1:0]  w_idx;
    logic             w_accept;
    logic             w_en;

    logic [ID_W-1:0]  ptr_q, ptr_d;
    sbox_byte_t       x_q, x_d;
    sbox_dir_e        inv_q, inv_d;
    logic             vld_q, vld_d;
    logic [ID_W-1:0]  id_q, id_d;

    logic             w_last_vld;
    logic [ID_W-1:0]  w_last_id;
    logic             w_pipe_busy;

    assign w_en = ~rst & ~bus.flush;

    sbox_rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_arb (
        .req_i (bus.req_valid),
        .ptr_i (ptr_q),
        .en_i  (w_en),
        .gnt_o (w_gnt),
        .idx_o (w_idx),
        .any_o (w_accept)
    );

    assign bus.req_ready = w_gnt;

    // Byte and direction only reload on accept so the datapath input stays quiet
    always_comb begin
        ptr_d = ptr_q;
        x_d   = x_q;
        inv_d = inv_q;
        id_d  = id_q;
        vld_d = w_accept;
        if (w_accept) begin
            x_d   = bus.req_data[{w_idx, 3'b000} +: SBOX_W];
            inv_d = sbox_dir_e'(bus.req_inv[w_idx]);
            id_d  = w_idx;
            ptr_d = (w_idx == ID_W'(N_REQ-1)) ? '0 : w_idx + ID_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
            x_q   <= '0;
            inv_q <= DIR_FWD;
            vld_q <= 1'b0;
            id_q  <= '0;
        end else begin
            ptr_q <= ptr_d;
            x_q   <= x_d;
            inv_q <= inv_d;
            vld_q <= vld_d;
            id_q  <= id_d;
        end
    end

    assign bus.sbox_x   = x_q;
    assign bus.sbox_inv = inv_q;
    assign bus.sbox_vld = vld_q;

    generate
        if (SBOX_LAT == 0) begin : g_lat0
            assign w_last_vld  = vld_q;
            assign w_last_id   = id_q;
            assign w_pipe_busy = 1'b0;
        end else begin : g_pipe
            logic [SBOX_LAT-1:0] tag_vld_q;
            logic [ID_W-1:0]     tag_id_q [SBOX_LAT];

            always_ff @(posedge clk) begin
                tag_id_q[0] <= id_q;
                for (int k = 1; k < SBOX_LAT; k++) begin
                    tag_id_q[k] <= tag_id_q[k-1];
                end
                if (rst || bus.flush) begin
                    tag_vld_q <= '0;
                end else begin
                    tag_vld_q[0] <= vld_q;
                    for (int k = 1; k < SBOX_LAT; k++) begin
                        tag_vld_q[k] <= tag_vld_q[k-1];
                    end
                end
            end

            assign w_last_vld  = tag_vld_q[SBOX_LAT-1];
            assign w_last_id   = tag_id_q[SBOX_LAT-1];
            assign w_pipe_busy = |tag_vld_q;
        end
    endgenerate

    always_comb begin
        bus.rsp_valid = '0;
        if (w_last_vld) begin
            bus.rsp_valid[w_last_id] = 1'b1;
        end
    end

    assign bus.rsp_data = bus.sbox_y;
    assign bus.busy     = vld_q | w_pipe_busy;

endmodule

`default_nettype wire

// File: tb/tb_sbox_share_ctrl.sv
// ============================================================================
// Module  : tb_sbox_share_ctrl
// Brief   : Scoreboard bench for sbox_share_ctrl around a 3-stage AES S-box.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_sbox_share_ctrl;

    typedef struct {
        int         id;
        logic [7:0] data;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sbox_share_ctrl_if #(.N_REQ(4)) bus ();

    sbox_share_ctrl #(
        .N_REQ    (4),
        .SBOX_LAT (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [7:0] fwd_tab [256];
    logic [7:0] inv_tab [256];
    logic [7:0] p1, p2, p3;

    // External merged S-box: three register stages
    always @(posedge clk) begin
        p1 <= bus.sbox_inv ? inv_tab[bus.sbox_x] : fwd_tab[bus.sbox_x];
        p2 <= p1;
        p3 <= p2;
    end
    assign bus.sbox_y = p3;

    exp_t sb_q [$];
    exp_t mon_e;
    int   ptr_m = 0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   rsp_cnt = 0;
    int   first_rsp = -1;
    int   last_rsp = -1;
    bit   mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        logic       hi;
        p = 8'h00; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            hi = aa[7];
            aa = {aa[6:0], 1'b0};
            if (hi) aa = aa ^ 8'h1b;
            bb = {1'b0, bb[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    task automatic build_tables();
        logic [7:0] x, y, s;
        for (int i = 0; i < 256; i++) begin
            x = 8'(i);
            y = 8'h00;
            for (int j = 1; j < 256; j++) begin
                if (gmul(x, 8'(j)) == 8'h01) y = 8'(j);
            end
            s = y ^ rotl(y, 1) ^ rotl(y, 2) ^ rotl(y, 3) ^ rotl(y, 4) ^ 8'h63;
            fwd_tab[i] = s;
            inv_tab[s] = x;
        end
    endtask

    always @(negedge clk) begin
        if (mon_en && bus.rsp_valid !== 4'b0000) begin
            rsp_cnt = rsp_cnt + 1;
            if (first_rsp < 0) first_rsp = cyc;
            last_rsp = cyc;
            n_checks = n_checks + 1;
            if (sb_q.size() == 0) begin
                n_fail = n_fail + 1;
                $display("FAIL rsp_unexpected: got rsp_valid=%b expected 0000", bus.rsp_valid);
            end else begin
                mon_e = sb_q.pop_front();
                if (bus.rsp_valid !== 4'(1 << mon_e.id)) begin
                    n_fail = n_fail + 1;
                    $display("FAIL rsp_valid: got %b expected %b", bus.rsp_valid, 4'(1 << mon_e.id));
                end
                n_checks = n_checks + 1;
                if (bus.rsp_data !== mon_e.data) begin
                    n_fail = n_fail + 1;
                    $display("FAIL rsp_data: got %h expected %h", bus.rsp_data, mon_e.data);
                end
                n_checks = n_checks + 1;
                if (cyc - mon_e.cyc != 4) begin
                    n_fail = n_fail + 1;
                    $display("FAIL rsp_latency: got %0d expected 4", cyc - mon_e.cyc);
                end
            end
        end
    end

    // One cycle of requester stimulus; predicts the grant and queues its result
    task automatic cycle_req(input logic [3:0] v, input logic [31:0] d, input logic [3:0] inv,
                             input logic fl, output logic [3:0] rdy);
        int         g;
        logic [3:0] exp_rdy;
        logic [7:0] b;
        bus.req_valid = v;
        bus.req_data  = d;
        bus.req_inv   = inv;
        bus.flush     = fl;
        #1;
        g = -1;
        if (!fl && !rst) begin
            for (int k = 0; k < 4; k++) begin
                if (g < 0 && v[(ptr_m + k) % 4]) g = (ptr_m + k) % 4;
            end
        end
        exp_rdy = (g >= 0) ? 4'(1 << g) : 4'b0000;
        rdy = bus.req_ready;
        n_checks = n_checks + 1;
        if (bus.req_ready !== exp_rdy) begin
            n_fail = n_fail + 1;
            $display("FAIL req_ready: got %b expected %b", bus.req_ready, exp_rdy);
        end
        if (g >= 0) begin
            b = d[8*g +: 8];
            sb_q.push_back('{id: g, data: (inv[g] ? inv_tab[b] : fwd_tab[b]), cyc: cyc});
            ptr_m = (g + 1) % 4;
        end
        if (fl) sb_q.delete();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        logic [3:0] r;
        for (int i = 0; i < n; i++) cycle_req(4'b0000, 32'h0, 4'b0000, 1'b0, r);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sb_q.size() != 0; i++) idle(1);
        idle(1);
        n_checks = n_checks + 1;
        if (sb_q.size() != 0) begin
            n_fail = n_fail + 1;
            $display("FAIL drain: got %0d pending expected 0", sb_q.size());
        end
    endtask

    task automatic check_quiet(input string name);
        n_checks = n_checks + 1;
        if ({bus.sbox_vld, bus.sbox_x, bus.sbox_inv, bus.rsp_valid, bus.busy} !== 15'h0) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got vld=%b x=%h inv=%b rsp=%b busy=%b expected all 0", name,
                     bus.sbox_vld, bus.sbox_x, bus.sbox_inv, bus.rsp_valid, bus.busy);
        end
    endtask

    task automatic test_reset();
        logic [3:0] r;
        rst = 1'b1;
        cycle_req(4'b1111, 32'hdeadbeef, 4'b1010, 1'b0, r);
        cycle_req(4'b1111, 32'hdeadbeef, 4'b1010, 1'b0, r);
        check_quiet("reset_state");
        rst = 1'b0;
        ptr_m = 0;
        sb_q.delete();
        mon_en = 1'b1;
        idle(1);
    endtask

    task automatic check_rsp(input string name, input logic [3:0] v, input logic [7:0] dat);
        n_checks = n_checks + 1;
        if (bus.rsp_valid !== v || bus.rsp_data !== dat) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %b/%h expected %b/%h", name, bus.rsp_valid, bus.rsp_data, v, dat);
        end
    endtask

    task automatic test_single_fwd();
        logic [3:0] r;
        cycle_req(4'b0001, 32'h00000000, 4'b0000, 1'b0, r);
        cycle_req(4'b0001, 32'h00000053, 4'b0000, 1'b0, r);
        idle(2);
        check_rsp("fwd_00", 4'b0001, 8'h63);
        idle(1);
        check_rsp("fwd_53", 4'b0001, 8'hed);
        drain();
    endtask

    task automatic test_single_inv();
        logic [3:0] r;
        cycle_req(4'b0100, 32'h00630000, 4'b0100, 1'b0, r);
        cycle_req(4'b0100, 32'h00ed0000, 4'b0100, 1'b0, r);
        idle(2);
        check_rsp("inv_63", 4'b0100, 8'h00);
        idle(1);
        check_rsp("inv_ed", 4'b0100, 8'h53);
        drain();
    endtask

    task automatic test_back_to_back();
        logic [3:0] r;
        if (ptr_m != 0) cycle_req(4'(1 << ptr_m) | 4'b1000, 32'h0, 4'b0000, 1'b0, r);
        drain();
        rsp_cnt = 0; first_rsp = -1; last_rsp = -1;
        for (int i = 0; i < 8; i++) begin
            cycle_req(4'b1111, $urandom, 4'($urandom_range(0, 15)), 1'b0, r);
            n_checks = n_checks + 1;
            if (r !== 4'(1 << (i % 4))) begin
                n_fail = n_fail + 1;
                $display("FAIL b2b_grant%0d: got %b expected %b", i, r, 4'(1 << (i % 4)));
            end
        end
        drain();
        n_checks = n_checks + 1;
        if (rsp_cnt != 8 || last_rsp - first_rsp != 7) begin
            n_fail = n_fail + 1;
            $display("FAIL b2b_pulses: got %0d pulses span %0d expected 8 span 7",
                     rsp_cnt, last_rsp - first_rsp);
        end
    endtask

    task automatic test_wrap_skip();
        logic [3:0] r;
        cycle_req(4'b0100, 32'h00a50000, 4'b0000, 1'b0, r);
        cycle_req(4'b0010, 32'h00003c00, 4'b0010, 1'b0, r);
        n_checks = n_checks + 1;
        if (r !== 4'b0010) begin
            n_fail = n_fail + 1;
            $display("FAIL wrap_skip: got %b expected 0010", r);
        end
        cycle_req(4'b1111, 32'h11223344, 4'b0000, 1'b0, r);
        n_checks = n_checks + 1;
        if (r !== 4'b0100) begin
            n_fail = n_fail + 1;
            $display("FAIL wrap_ptr: got %b expected 0100", r);
        end
        drain();
    endtask

    task automatic test_flush();
        logic [3:0] r;
        int         w;
        rsp_cnt = 0;
        for (int i = 0; i < 3; i++) cycle_req(4'b0001, 32'h000000f0 + i, 4'b0000, 1'b0, r);
        cycle_req(4'b1111, 32'h55555555, 4'b0000, 1'b1, r);
        w = 0;
        while (bus.busy !== 1'b0 && w < 4) begin
            idle(1);
            w++;
        end
        n_checks = n_checks + 1;
        if (bus.busy !== 1'b0) begin
            n_fail = n_fail + 1;
            $display("FAIL flush_busy: got %b expected 0", bus.busy);
        end
        idle(6);
        n_checks = n_checks + 1;
        if (rsp_cnt != 0) begin
            n_fail = n_fail + 1;
            $display("FAIL flush_pulses: got %0d expected 0", rsp_cnt);
        end
        cycle_req(4'b1111, 32'h9a8b7c6d, 4'b0000, 1'b0, r);
        n_checks = n_checks + 1;
        if (r !== 4'b0010) begin
            n_fail = n_fail + 1;
            $display("FAIL flush_ptr_hold: got %b expected 0010", r);
        end
        drain();
    endtask

    task automatic test_reset_inflight();
        logic [3:0] r;
        for (int i = 0; i < 3; i++) cycle_req(4'b0001, 32'h00000077, 4'b0001, 1'b0, r);
        rst = 1'b1;
        sb_q.delete();
        ptr_m = 0;
        cycle_req(4'b1111, 32'h12345678, 4'b1111, 1'b0, r);
        check_quiet("reset_inflight");
        rst = 1'b0;
        rsp_cnt = 0;
        idle(6);
        n_checks = n_checks + 1;
        if (rsp_cnt != 0) begin
            n_fail = n_fail + 1;
            $display("FAIL reset_stale: got %0d pulses expected 0", rsp_cnt);
        end
    endtask

    task automatic test_sweep();
        logic [3:0] r;
        for (int q = 0; q < 4; q++) begin
            for (int dir = 0; dir < 2; dir++) begin
                for (int b = 0; b < 256; b++) begin
                    cycle_req(4'(1 << q), 32'(b) << (8 * q), 4'(dir << q), 1'b0, r);
                end
            end
        end
        drain();
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.req_inv   = '0;
        bus.flush     = 1'b0;
        build_tables();
        @(negedge clk);
        test_reset();
        test_single_fwd();
        test_single_inv();
        test_back_to_back();
        test_wrap_skip();
        test_flush();
        test_reset_inflight();
        test_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
